// File: rtl/set_associative_cache_memory_if.sv
// Request and memory bus bundle for set_associative_cache_memory.
// slave: cache side; master: request generator / main memory side.
interface set_associative_cache_memory_if #(
    parameter int unsigned AddrW    = 20,
    parameter int unsigned DataW    = 64,
    parameter int unsigned BlockW   = 512,
    parameter int unsigned SizeW    = 7,
    parameter int unsigned MemAddrW = 14
);
    logic                enable_in;
    logic                read_in;
    logic                write_in;
    logic [AddrW-1:0]    address_in;
    logic [SizeW-1:0]    data_size_in;
    logic [DataW-1:0]    data_in;
    logic [BlockW-1:0]   mem_data_in;
    logic [DataW-1:0]    data_out;
    logic                busy_out;
    logic                mem_read_out;
    logic                mem_write_out;
    logic [MemAddrW-1:0] mem_address_out;
    logic [BlockW-1:0]   mem_data_out;

    modport master (
        output enable_in, read_in, write_in, address_in, data_size_in, data_in, mem_data_in,
        input  data_out, busy_out, mem_read_out, mem_write_out, mem_address_out, mem_data_out
    );

    modport slave (
        input  enable_in, read_in, write_in, address_in, data_size_in, data_in, mem_data_in,
        output data_out, busy_out, mem_read_out, mem_write_out, mem_address_out, mem_data_out
    );
endinterface

// File: rtl/set_associative_cache_memory.sv
// Write-back, write-allocate, 4-way set-associative cache with true-LRU ages.
// Optional hit/miss counters are enabled with the CACHE_STATS_EN macro.
module set_associative_cache_memory #(
    parameter int unsigned CacheSize              = 262144,
    parameter int unsigned CacheBlock             = 512,
    parameter int unsigned AddressSize            = 20,
    parameter int unsigned MinimumAddressibleSize = 8,
    parameter int unsigned MaximumDataSize        = 64,
    parameter int unsigned NoOfWays               = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    set_associative_cache_memory_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                  hit_count_out,
    output logic [31:0]                  miss_count_out
`endif
);
    localparam int unsigned OffW  = $clog2(CacheBlock / MinimumAddressibleSize);
    localparam int unsigned Sets  = CacheSize / (CacheBlock * NoOfWays);
    localparam int unsigned IdxW  = $clog2(Sets);
    localparam int unsigned TagW  = AddressSize - OffW - IdxW;
    localparam int unsigned WayW  = $clog2(NoOfWays);
    localparam int unsigned DataW = MaximumDataSize;

    typedef enum logic [1:0] {StIdle, StLookup, StWriteback, StFill} state_e;

    state_e                 state_q, state_d;
    logic [AddressSize-1:0] addr_q;
    logic [3:0]             nbytes_q;
    logic [DataW-1:0]       wdata_q;
    logic                   is_write_q;
    logic [WayW-1:0]        victim_q;
    logic [DataW-1:0]       data_out_q;
    logic                   hit_miss_q;

    logic                   valid_q [Sets][NoOfWays];
    logic                   dirty_q [Sets][NoOfWays];
    logic [TagW-1:0]        tag_q   [Sets][NoOfWays];
    logic [WayW-1:0]        age_q   [Sets][NoOfWays];
    logic [CacheBlock-1:0]  data_q  [Sets][NoOfWays];

    logic [TagW-1:0]        req_tag;
    logic [IdxW-1:0]        idx;
    logic [OffW-1:0]        off;
    logic [3:0]             size_bytes;
    logic                   accept;
    logic                   hit, found_free, done;
    logic [WayW-1:0]        hit_way, victim, acc_way;
    logic [CacheBlock-1:0]  acc_line, new_line;
    logic [DataW-1:0]       rdata;
    logic [6:0]             pos;

    assign req_tag    = addr_q[AddressSize-1 -: TagW];
    assign idx        = addr_q[OffW +: IdxW];
    assign off        = addr_q[OffW-1:0];
    // Whole bytes only, clamped to the widest access.
    assign size_bytes = (bus.data_size_in[6:3] > 4'd8) ? 4'd8 : bus.data_size_in[6:3];
    assign accept     = bus.enable_in && (bus.read_in || bus.write_in);
    assign done       = (state_q == StLookup && hit) || (state_q == StFill);
    assign acc_way    = (state_q == StFill) ? victim_q : hit_way;
    assign acc_line   = (state_q == StFill) ? bus.mem_data_in : data_q[idx][acc_way];
    assign bus.data_out = data_out_q;

    // Tag compare and victim choice: lowest invalid way, else the LRU (age all-ones) way.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim     = '0;
        found_free = 1'b0;
        for (int w = 0; w < NoOfWays; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
        for (int w = NoOfWays - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                found_free = 1'b1;
                victim     = WayW'(w);
            end
        end
        if (!found_free) begin
            for (int w = 0; w < NoOfWays; w++) begin
                if (age_q[idx][w] == '1) victim = WayW'(w);
            end
        end
    end

    // Byte-lane access on the selected line; bytes past the block end are dropped.
    always_comb begin
        new_line = acc_line;
        rdata    = '0;
        pos      = '0;
        for (int k = 0; k < 8; k++) begin
            pos = {1'b0, off} + 7'(k);
            if (4'(k) < nbytes_q && !pos[6]) begin
                rdata[8*k +: 8] = acc_line[{pos[5:0], 3'b000} +: 8];
                if (is_write_q) new_line[{pos[5:0], 3'b000} +: 8] = wdata_q[8*k +: 8];
            end
        end
    end

    // Next state and Moore memory-side outputs.
    always_comb begin
        state_d             = state_q;
        bus.busy_out        = (state_q != StIdle);
        bus.mem_read_out    = 1'b0;
        bus.mem_write_out   = 1'b0;
        bus.mem_address_out = '0;
        bus.mem_data_out    = '0;
        unique case (state_q)
            StIdle:   if (accept) state_d = StLookup;
            StLookup: begin
                if (hit) state_d = StIdle;
                else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = StWriteback;
                else state_d = StFill;
            end
            StWriteback: begin
                bus.mem_write_out   = 1'b1;
                bus.mem_address_out = {tag_q[idx][victim_q], idx};
                bus.mem_data_out    = data_q[idx][victim_q];
                state_d             = StFill;
            end
            StFill: begin
                bus.mem_read_out    = 1'b1;
                bus.mem_address_out = {req_tag, idx};
                state_d             = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, request latch, victim, result registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            nbytes_q   <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            victim_q   <= '0;
            data_out_q <= '0;
            hit_miss_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && accept) begin
                addr_q     <= bus.address_in;
                nbytes_q   <= size_bytes;
                wdata_q    <= bus.data_in;
                is_write_q <= bus.write_in && !bus.read_in;
            end
            if (state_q == StLookup) begin
                hit_miss_q <= hit;
                if (!hit) victim_q <= victim;
            end
            if (done && !is_write_q) data_out_q <= rdata;
        end
    end

    // Line metadata and LRU ages; the accessed way becomes MRU.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < Sets; s++) begin
                for (int w = 0; w < NoOfWays; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WayW'(w);
                end
            end
        end else if (done) begin
            valid_q[idx][acc_way] <= 1'b1;
            if (state_q == StFill) begin
                tag_q[idx][acc_way]   <= req_tag;
                dirty_q[idx][acc_way] <= is_write_q;
            end else if (is_write_q) begin
                dirty_q[idx][acc_way] <= 1'b1;
            end
            for (int w = 0; w < NoOfWays; w++) begin
                if (WayW'(w) == acc_way) age_q[idx][w] <= '0;
                else if (age_q[idx][w] < age_q[idx][acc_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
        end
    end

    // Line data array, written on every completed access.
    always_ff @(posedge clk_in) begin
        if (done) data_q[idx][acc_way] <= new_line;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters, updated in LOOKUP.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StLookup) begin
            if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`endif
endmodule

// File: tb/tb_set_associative_cache_memory.sv
// Directed bench for set_associative_cache_memory with a read-only patterned memory.
module tb_set_associative_cache_memory;
    logic clk_in;
    logic rst_n_in;
    int   total = 0;
    int   bad   = 0;

    int           busy_cycles, n_rd, n_wr;
    logic [13:0]  rd_addr, wb_addr;
    logic [511:0] wb_data;

    set_associative_cache_memory_if bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    set_associative_cache_memory dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_out  (hit_cnt),
        .miss_count_out (miss_cnt)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Block a, byte o = (a[7:0] ^ {a[13:8],2'b00}) + o.
    function automatic logic [511:0] blk(input logic [13:0] a);
        logic [7:0] b;
        b = a[7:0] ^ {a[13:8], 2'b00};
        for (int o = 0; o < 64; o++) blk[8*o +: 8] = b + 8'(o);
    endfunction

    always_comb bus.mem_data_in = bus.mem_read_out ? blk(bus.mem_address_out) : '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle request strobe, then count busy cycles and memory strobes.
    task automatic do_req(input logic rd, input logic wr, input logic [19:0] a,
                          input logic [6:0] sz, input logic [63:0] d);
        @(negedge clk_in);
        bus.enable_in    = 1'b1;
        bus.read_in      = rd;
        bus.write_in     = wr;
        bus.address_in   = a;
        bus.data_size_in = sz;
        bus.data_in      = d;
        @(negedge clk_in);
        bus.enable_in = 1'b0;
        bus.read_in   = 1'b0;
        bus.write_in  = 1'b0;
        busy_cycles = 0;
        n_rd = 0;
        n_wr = 0;
        while (bus.busy_out && busy_cycles < 20) begin
            busy_cycles++;
            if (bus.mem_read_out) begin
                n_rd++;
                rd_addr = bus.mem_address_out;
            end
            if (bus.mem_write_out) begin
                n_wr++;
                wb_addr = bus.mem_address_out;
                wb_data = bus.mem_data_out;
            end
            @(negedge clk_in);
        end
    endtask

    initial begin
        int waited;
        bus.enable_in    = 1'b0;
        bus.read_in      = 1'b0;
        bus.write_in     = 1'b0;
        bus.address_in   = '0;
        bus.data_size_in = '0;
        bus.data_in      = '0;
        rd_addr = '0;
        wb_addr = '0;
        wb_data = '0;
        rst_n_in = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy_out), 64'd0);
        chk("rst_mem_rd", 64'(bus.mem_read_out), 64'd0);
        chk("rst_mem_wr", 64'(bus.mem_write_out), 64'd0);
        chk("rst_data_out", bus.data_out, 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_address_out), 64'd0);
        chk("rst_hit_miss", 64'(dut.hit_miss_q), 64'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Cold read.
        do_req(1'b1, 1'b0, 20'h00040, 7'd64, 64'd0);
        chk("cold_busy", 64'(busy_cycles), 64'd2);
        chk("cold_nrd", 64'(n_rd), 64'd1);
        chk("cold_nwr", 64'(n_wr), 64'd0);
        chk("cold_rdaddr", 64'(rd_addr), 64'h0001);
        chk("cold_data", bus.data_out, 64'h0807060504030201);
        chk("cold_hm", 64'(dut.hit_miss_q), 64'd0);

        // Write hit, then read back.
        do_req(1'b0, 1'b1, 20'h00044, 7'd32, 64'h00000000DEADBEEF);
        chk("wr_busy", 64'(busy_cycles), 64'd1);
        chk("wr_hm", 64'(dut.hit_miss_q), 64'd1);
        chk("wr_data_out_kept", bus.data_out, 64'h0807060504030201);
        do_req(1'b1, 1'b0, 20'h00044, 7'd32, 64'd0);
        chk("rb_busy", 64'(busy_cycles), 64'd1);
        chk("rb_data", bus.data_out, 64'h00000000DEADBEEF);
        chk("rb_hm", 64'(dut.hit_miss_q), 64'd1);

        // Fill the remaining ways of set 1.
        do_req(1'b1, 1'b0, 20'h02040, 7'd64, 64'd0);
        chk("fill1_busy", 64'(busy_cycles), 64'd2);
        chk("fill1_hm", 64'(dut.hit_miss_q), 64'd0);
        do_req(1'b1, 1'b0, 20'h04040, 7'd64, 64'd0);
        chk("fill2_busy", 64'(busy_cycles), 64'd2);
        do_req(1'b1, 1'b0, 20'h06040, 7'd64, 64'd0);
        chk("fill3_busy", 64'(busy_cycles), 64'd2);
        chk("fill3_rdaddr", 64'(rd_addr), 64'h0181);

        // Dirty LRU eviction.
        do_req(1'b1, 1'b0, 20'h08040, 7'd64, 64'd0);
        chk("ev_busy", 64'(busy_cycles), 64'd3);
        chk("ev_nwr", 64'(n_wr), 64'd1);
        chk("ev_wbaddr", 64'(wb_addr), 64'h0001);
        chk("ev_wbdata", wb_data[63:0], 64'hDEADBEEF04030201);
        chk("ev_nrd", 64'(n_rd), 64'd1);
        chk("ev_rdaddr", 64'(rd_addr), 64'h0201);
        chk("ev_data", bus.data_out, 64'h100F0E0D0C0B0A09);
        chk("ev_hm", 64'(dut.hit_miss_q), 64'd0);

        // Last byte of the block; the second byte falls off the end.
        do_req(1'b1, 1'b0, 20'h0007F, 7'd16, 64'd0);
        chk("edge_busy", 64'(busy_cycles), 64'd2);
        chk("edge_data", bus.data_out, 64'h0000000000000040);
        do_req(1'b1, 1'b0, 20'h0007F, 7'd0, 64'd0);
        chk("zero_data", bus.data_out, 64'd0);
        chk("zero_hm", 64'(dut.hit_miss_q), 64'd1);

        // Enable held into the busy cycle with a missing address: must be ignored.
        @(negedge clk_in);
        bus.enable_in    = 1'b1;
        bus.read_in      = 1'b1;
        bus.address_in   = 20'h00040;
        bus.data_size_in = 7'd64;
        @(negedge clk_in);
        chk("hs_busy_on", 64'(bus.busy_out), 64'd1);
        bus.address_in = 20'h0A040;
        @(negedge clk_in);
        bus.enable_in = 1'b0;
        bus.read_in   = 1'b0;
        chk("hs_busy_off", 64'(bus.busy_out), 64'd0);
        chk("hs_data", bus.data_out, 64'h0807060504030201);
        @(negedge clk_in);
        chk("hs_no_second", 64'(bus.busy_out | bus.mem_read_out), 64'd0);

        // Read and write together act as a read.
        do_req(1'b1, 1'b1, 20'h00048, 7'd64, 64'h1122334455667788);
        chk("rw_data", bus.data_out, 64'h100F0E0D0C0B0A09);
        chk("rw_hm", 64'(dut.hit_miss_q), 64'd1);
        do_req(1'b1, 1'b0, 20'h00048, 7'd64, 64'd0);
        chk("rw_unchanged", bus.data_out, 64'h100F0E0D0C0B0A09);

        // Reset while FILL is driving the memory strobe.
        @(negedge clk_in);
        bus.enable_in    = 1'b1;
        bus.read_in      = 1'b1;
        bus.address_in   = 20'h0C040;
        bus.data_size_in = 7'd64;
        @(negedge clk_in);
        bus.enable_in = 1'b0;
        bus.read_in   = 1'b0;
        waited = 0;
        while (!bus.mem_read_out && waited < 5) begin
            waited++;
            @(negedge clk_in);
        end
        chk("rf_reached_fill", 64'(bus.mem_read_out), 64'd1);
        rst_n_in = 1'b0;
        #1;
        chk("rf_busy", 64'(bus.busy_out), 64'd0);
        chk("rf_mem_rd", 64'(bus.mem_read_out), 64'd0);
        chk("rf_mem_wr", 64'(bus.mem_write_out), 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        do_req(1'b1, 1'b0, 20'h0C040, 7'd64, 64'd0);
        chk("rf_re_hm", 64'(dut.hit_miss_q), 64'd0);
        chk("rf_re_busy", 64'(busy_cycles), 64'd2);
        chk("rf_re_data", bus.data_out, 64'h14131211100F0E0D);
        do_req(1'b1, 1'b0, 20'h00040, 7'd64, 64'd0);
        chk("rf_cold_hm", 64'(dut.hit_miss_q), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/set_associative_cache_memory.md
# set_associative_cache_memory

Write-back, write-allocate, N-way set-associative cache between a request generator (byte-addressed, up to 64-bit accesses) and a block-wide main memory. Requests are accepted on a single-cycle strobe and served under a busy handshake. Misses trigger an optional victim writeback, then a block fill, through a single-cycle memory strobe interface. An internal `hit_miss` flag records the outcome of each request for hit/miss accounting by the bench.

## Interface
- `cache_size`, 262144: capacity in bits (32 KiB).
- `cache_block`, 512: block size in bits.
- `address_size`, 20: byte address width.
- `minimum_addressible_size`, 8: bits per address unit.
- `maximum_data_size`, 64: max access width in bits.
- `no_of_ways`, 4: associativity.
- Derived: OFF = log2(cache_block/8) = 6; SETS = cache_size/(cache_block·no_of_ways) = 128; IDX = 7; TAG = address_size−OFF−IDX = 7.

Ports:
- `clk_in` in 1: clock; all state changes on rising edge.
- `rst_n_in` in 1: asynchronous active-low reset.
- `enable_in` in 1: request strobe.
- `read_in` in 1: read request.
- `write_in` in 1: write request.
- `address_in` in 20: byte address. Bits [19:13] are tag, [12:6] are index, [5:0] are offset.
- `data_size_in` in 7: access size in bits. Only whole bytes are used (value>>3).
- `data_in` in 64: write data.
- `mem_data_in` in 512: block from memory, combinational while `mem_read_out`=1.
- `data_out` out 64: read data.
- `busy_out` out 1: request in progress.
- `mem_read_out` out 1: block read strobe.
- `mem_write_out` out 1: block write strobe.
- `mem_address_out` out 14: block address {tag,index}.
- `mem_data_out` out 512: writeback block.

## Operation
- Per line: valid, dirty, tag, 512-bit data. Per set: 2-bit LRU age per way; ages are distinct, 0 = MRU and 3 = LRU.
- Byte o of a block occupies bits [8o+7:8o].
- Access covers nbytes = data_size_in>>3, clamped to 8, starting at the offset. Bytes beyond offset 63 are dropped; an access never crosses into the next block.
- Read: `data_out`[8k+7:8k] = byte offset+k for k<nbytes; the remaining upper bits are 0.
- Write: byte offset+k ← `data_in`[8k+7:8k] for k<nbytes; the line's dirty bit is set.
- nbytes = 0: lookup and allocation still occur, no data changes, and a read returns 0.
- Victim selection: the lowest-index invalid way, else the way with age 3.
- LRU update on every completed access: the accessed way's age becomes 0; ways whose age was lower than the accessed way's old age increment by 1.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL.
  - IDLE → LOOKUP when `enable_in`=1 and (`read_in` or `write_in`). Address, size, data and op are latched on this transition.
  - LOOKUP: `hit_miss` ← hit.
    - Hit: perform the access, go to IDLE.
    - Miss with dirty victim: go to WRITEBACK.
    - Miss otherwise: go to FILL.
  - WRITEBACK: `mem_write_out`=1, `mem_address_out`={victim tag, index}, `mem_data_out`=victim data. Then go to FILL.
  - FILL: `mem_read_out`=1, `mem_address_out`={req tag, index}. On the edge: line ← `mem_data_in`, valid=1, dirty=0, tag set; then the access is performed (which may set dirty); go to IDLE.
- `read_in` and `write_in` both 1: treated as a read.
- `enable_in` while busy is ignored.
- `data_out` changes only on read completion; writes leave it unchanged.
- `hit_miss` holds its value until the next LOOKUP.

## Timing
- Reset (async):
  - All outputs are 0, FSM is in IDLE, `hit_miss`=0.
  - All valid/dirty bits cleared; ways' ages = way index.
  - Reset mid-operation aborts the request with no memory strobe, and dirty data is lost.
- `busy_out`=1 in every non-IDLE state.
- Busy duration by outcome: hit 1 cycle, clean miss 2 cycles, dirty miss 3 cycles.
- Memory strobes last exactly one cycle. Memory writes at the end of the WRITEBACK cycle.
- Results are visible when `busy_out` falls: `data_out` and `hit_miss` are valid at that edge.
- Outside their states, `mem_data_out` and `mem_address_out` hold 0.

## Configuration
- `CACHE_STATS_EN` defined: adds outputs `hit_count_out` [31:0] and `miss_count_out` [31:0].
  - Each increments at LOOKUP according to the outcome and saturates at 0xFFFFFFFF.
  - Both reset to 0.
- `CACHE_STATS_EN` undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Cold read: after reset, read 64 bits at 0x00040.
  - `mem_read_out` pulses once with `mem_address_out`=0x0001; `busy_out` is high 2 cycles.
  - `data_out` = memory block 1 bytes 0–7; `hit_miss`=0.
- Write then read:
  - Write 32 bits 0xDEADBEEF at 0x00044 → hit, busy 1 cycle.
  - Read 32 bits at 0x00044 → `data_out`=0x00000000DEADBEEF, `hit_miss`=1.
- Eviction:
  - Read 0x02040, 0x04040, 0x06040 (set 1 is now full), then read 0x08040.
  - Required: writeback with `mem_address_out`=0x0001 and `mem_data_out` bits [63:32]=0xDEADBEEF, then fill at 0x0201; busy 3 cycles.
- Boundary:
  - Read 16 bits at 0x0007F → `data_out`[7:0] = byte 63 of block 1, [63:8]=0.
  - Read with `data_size_in`=0 → `data_out`=0.
- Handshake:
  - Pulse `enable_in` during busy → ignored, no second request.
  - `read_in`=`write_in`=1 → read performed, contents unchanged.
- Reset during FILL:
  - `busy_out` and strobes drop immediately.
  - Re-reading the same address misses with `hit_miss`=0.
